// File: rtl/led_trail_pwm.sv
// Fading LED trail: each channel loads full brightness on a step-pattern rise, then decays per prescaler tick, driving PWM.
// Latency: LEVEL updates at the edge after a rise, LED one cycle later; no backpressure, EN=0 blanks and clears.
module led_trail_pwm #(
    parameter int DECAY_DIV  = 100_000,
    parameter int DECAY_STEP = 8
) (
    input  logic        SCK,
    input  logic        RST,
    input  logic        EN,
    input  logic [3:0]  PIN_IN,
    output logic [3:0]  LED,
    output logic [31:0] LEVEL
);

    localparam logic [23:0] LP_LAST = 24'(DECAY_DIV - 1);
    localparam logic [7:0]  LP_STEP = 8'(DECAY_STEP);

    logic [3:0]       r_pin_d;
    logic [23:0]      r_pre;
    logic [7:0]       r_pwm;
    logic [3:0][7:0]  r_level;
    logic [3:0]       r_led;

    logic [3:0]       w_rise;
    logic             w_tick;
    logic [3:0][7:0]  w_level_nxt;
    logic [3:0]       w_led_nxt;

    assign w_rise = PIN_IN & ~r_pin_d;
    assign w_tick = (r_pre == LP_LAST);

    // A rise outranks a decay tick on the same channel.
    always_comb begin
        w_level_nxt = r_level;
        w_led_nxt   = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_rise[i]) begin
                w_level_nxt[i] = 8'hFF;
            end else if (w_tick) begin
                w_level_nxt[i] = (r_level[i] >= LP_STEP) ? (r_level[i] - LP_STEP) : 8'h00;
            end
            w_led_nxt[i] = (r_level[i] > r_pwm);
        end
    end

    // PIN_D keeps tracking while disabled so a bit held high across EN is not seen as a rise.
    always_ff @(posedge SCK) begin
        if (RST) begin
            r_pin_d <= '0;
            r_pre   <= '0;
            r_pwm   <= '0;
            r_level <= '0;
            r_led   <= '0;
        end else begin
            r_pin_d <= PIN_IN;
            if (!EN) begin
                r_pre   <= '0;
                r_pwm   <= '0;
                r_level <= '0;
                r_led   <= '0;
            end else begin
                r_pre   <= w_tick ? 24'd0 : (r_pre + 24'd1);
                r_pwm   <= r_pwm + 8'd1;
                r_level <= w_level_nxt;
                r_led   <= w_led_nxt;
            end
        end
    end

    assign LED   = r_led;
    assign LEVEL = r_level;

endmodule
